// File: rtl/count_check_pkg.sv
// Shared types for the counter sequence checker: FSM state encoding.
package count_check_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SYNC   = ST_SYNC,
        LOCKED = ST_LOCKED
    } state_t;

endpackage

// File: rtl/count_checker_if.sv
// Observation bus from the counter under check into the checker.
interface count_checker_if #(parameter int WIDTH = 8);

    logic [WIDTH-1:0] count_in;
    logic             valid_in;

    modport master (output count_in, output valid_in);
    modport slave  (input  count_in, input  valid_in);

endinterface

// File: rtl/sat_counter.sv
// Saturating incrementer with synchronous clear; clear plus increment loads 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/count_checker.sv
// Locks onto a +1-per-sample counter stream and flags every break after lock.
// Optional macro COUNT_CHECK_HOLD_EN: a repeated value (stalled counter) is legal.
module count_checker
    import count_check_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    count_checker_if.slave   bus,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] exp_bad,
    output logic [WIDTH-1:0] got_bad,
    output logic [1:0]       state
);

    localparam int RUN_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

    state_t           st;
    logic [WIDTH-1:0] prev;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt;
    logic [WIDTH-1:0] expv;
    logic             match;
    logic             hold;
    logic             err_det;

    assign expv    = prev + WIDTH'(1);
    assign match   = (bus.count_in == expv);
    assign run_nxt = run + RUN_W'(1);

`ifdef COUNT_CHECK_HOLD_EN
    assign hold = (bus.count_in == prev);
`else
    assign hold = 1'b0;
`endif

    // Breaks are only reported once locked; SYNC silently restarts its run.
    assign err_det = bus.valid_in && (st == LOCKED) && !match && !hold;
    assign state   = st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            prev      <= '0;
            run       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            exp_bad   <= '0;
            got_bad   <= '0;
        end else begin
            err_pulse <= err_det;
            if (err_det) begin
                exp_bad <= expv;
                got_bad <= bus.count_in;
            end else if (clear) begin
                exp_bad <= '0;
                got_bad <= '0;
            end

            if (bus.valid_in) begin
                prev <= bus.count_in;
                case (st)
                    IDLE: begin
                        run <= '0;
                        st  <= SYNC;
                    end
                    SYNC: begin
                        if (match) begin
                            run <= run_nxt;
                            if (run_nxt == RUN_W'(LOCK_CNT)) begin
                                st     <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (!hold) begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!match && !hold) begin
                            run    <= '0;
                            st     <= SYNC;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        st     <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (err_det),
        .cnt (err_count)
    );

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker (WIDTH=8, LOCK_CNT=4, ERR_W=2).
module tb_count_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       locked;
    logic       err_pulse;
    logic [1:0] err_count;
    logic [7:0] exp_bad;
    logic [7:0] got_bad;
    logic [1:0] state;

    int n_chk  = 0;
    int n_fail = 0;

    count_checker_if #(.WIDTH(8)) bus ();

    count_checker #(.WIDTH(8), .LOCK_CNT(4), .ERR_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .exp_bad   (exp_bad),
        .got_bad   (got_bad),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic step(input logic [7:0] v);
        bus.count_in = v;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Relock from prev=b with b+1..b+4, then present a jump of +100.
    task automatic relock_err(input logic [7:0] b);
        for (int i = 1; i <= 4; i++) step(8'(b + i));
        step(8'(b + 100));
    endtask

    initial begin
        logic [7:0] b;
        bus.count_in = '0;
        bus.valid_in = 1'b0;
        #12;
        chk("rst_locked", locked, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_count", err_count, 0);
        chk("rst_exp", exp_bad, 0);
        chk("rst_got", got_bad, 0);
        chk("rst_state", state, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Lock on 0..4
        step(8'd0);
        chk("lock_sync_state", state, 1);
        for (int v = 1; v <= 3; v++) begin
            step(8'(v));
            chk("lock_early", locked, 0);
        end
        step(8'd4);
        chk("lock_locked", locked, 1);
        chk("lock_state", state, 2);
        chk("lock_count", err_count, 0);
        step(8'd5);
        chk("lock_pulse5", err_pulse, 0);

        // Idle cycle with a garbage value must not be sampled
        bus.count_in = 8'd99;
        bus.valid_in = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_pulse", err_pulse, 0);
        chk("idle_state", state, 2);
        chk("idle_locked", locked, 1);

        // Wrap through 255 -> 0
        for (int v = 6; v <= 257; v++) begin
            step(8'(v));
            if (v >= 250) begin
                chk("wrap_pulse", err_pulse, 0);
                chk("wrap_locked", locked, 1);
            end
        end

        // Jump 11 -> 20
        for (int v = 2; v <= 11; v++) step(8'(v));
        step(8'd20);
        chk("jump_pulse", err_pulse, 1);
        chk("jump_count", err_count, 1);
        chk("jump_exp", exp_bad, 12);
        chk("jump_got", got_bad, 20);
        chk("jump_locked", locked, 0);
        chk("jump_state", state, 1);
        step(8'd21);
        chk("jump_pulse_once", err_pulse, 0);
        step(8'd22);
        step(8'd23);
        chk("relock_early", locked, 0);
        step(8'd24);
        chk("relock", locked, 1);

        // Stalled counter 30,30,31
        for (int v = 25; v <= 30; v++) step(8'(v));
        step(8'd30);
`ifdef COUNT_CHECK_HOLD_EN
        chk("hold_pulse", err_pulse, 0);
        chk("hold_locked", locked, 1);
        chk("hold_count", err_count, 1);
`else
        chk("hold_pulse", err_pulse, 1);
        chk("hold_count", err_count, 2);
        chk("hold_exp", exp_bad, 31);
        chk("hold_got", got_bad, 30);
        chk("hold_locked", locked, 0);
`endif
        step(8'd31);
        chk("hold_next_pulse", err_pulse, 0);

        // Clear alone: statistics zeroed, FSM untouched
        clear = 1'b1;
        bus.valid_in = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clr_count", err_count, 0);
        chk("clr_exp", exp_bad, 0);
        chk("clr_got", got_bad, 0);
`ifdef COUNT_CHECK_HOLD_EN
        chk("clr_locked", locked, 1);
`else
        chk("clr_locked", locked, 0);
`endif

        // Saturation: five errors with a 2-bit counter
        for (int v = 32; v <= 35; v++) step(8'(v));
        chk("sat_prelock", locked, 1);
        step(8'd100);
        chk("sat_err1", err_count, 1);
        b = 8'd100;
        for (int k = 2; k <= 5; k++) begin
            relock_err(b);
            chk("sat_pulse", err_pulse, 1);
            chk("sat_count", err_count, (k > 3) ? 3 : k);
            b = 8'(b + 100);
        end
        chk("sat_exp", exp_bad, 149);
        chk("sat_got", got_bad, 244);

        // Sixth error coincident with clear
        for (int i = 1; i <= 4; i++) step(8'(244 + i));
        clear = 1'b1;
        step(8'd0);
        clear = 1'b0;
        chk("clrerr_pulse", err_pulse, 1);
        chk("clrerr_count", err_count, 1);
        chk("clrerr_exp", exp_bad, 249);
        chk("clrerr_got", got_bad, 0);

        // Build up locked=1, err_count=3, then reset between edges
        relock_err(8'd0);
        chk("pre_rst_count2", err_count, 2);
        relock_err(8'd100);
        for (int v = 201; v <= 204; v++) step(8'(v));
        chk("pre_rst_locked", locked, 1);
        chk("pre_rst_count", err_count, 3);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_pulse", err_pulse, 0);
        chk("mid_rst_count", err_count, 0);
        chk("mid_rst_exp", exp_bad, 0);
        chk("mid_rst_got", got_bad, 0);
        chk("mid_rst_state", state, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int v = 0; v <= 3; v++) step(8'(v));
        chk("post_rst_early", locked, 0);
        step(8'd4);
        chk("post_rst_locked", locked, 1);
        chk("post_rst_state", state, 2);
        chk("post_rst_count", err_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
